// File: rtl/regram_pkg.sv
// Shared types for the vector register/RAM core.
// Opcodes, FSM states and the default lane-vector shape.
package regram_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_LANES = 16;

    typedef logic [DEF_LANES-1:0][DEF_WIDTH-1:0] lane_vec_t;

    typedef enum logic [2:0] {
        OP_RAM_TO_REG = 3'd0,
        OP_REG_TO_RAM = 3'd1,
        OP_ADDI       = 3'd2,
        OP_MULT       = 3'd3,
        OP_RAM_TO_OUT = 3'd4,
        OP_OUT_TO_RAM = 3'd5,
        OP_NOP6       = 3'd6,
        OP_NOP7       = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2
    } state_e;

endpackage

// File: rtl/vec_regram_core_if.sv
// Command handshake and host data bus of the vector register/RAM core.
interface vec_regram_core_if #(
    parameter int WIDTH  = 32,
    parameter int LANES  = 16,
    parameter int ADDR_W = 9,
    parameter int NREG   = 4
);
    logic                            cmd_valid;
    logic                            cmd_ready;
    logic [2:0]                      op;
    logic [ADDR_W-1:0]               ram_addr;
    logic [$clog2(LANES)-1:0]        ram_cnt;
    logic [$clog2(NREG)-1:0]         reg_sel;
    logic [$clog2(NREG)-1:0]         reg_src;
    logic [WIDTH-1:0]                imm;
    logic [LANES-1:0][WIDTH-1:0]     ram_input;
    logic [LANES-1:0][WIDTH-1:0]     ram_output;
    logic                            busy;
    logic                            done;

    modport master (
        output cmd_valid, op, ram_addr, ram_cnt,
        output reg_sel, reg_src, imm, ram_input,
        input  cmd_ready, ram_output, busy, done
    );

    modport slave (
        input  cmd_valid, op, ram_addr, ram_cnt,
        input  reg_sel, reg_src, imm, ram_input,
        output cmd_ready, ram_output, busy, done
    );
endinterface

// File: rtl/vec_ram.sv
// Line-wide RAM: registered read port, one write port with per-lane enables.
// Contents are never reset.
module vec_ram #(
    parameter int WIDTH  = 32,
    parameter int LANES  = 16,
    parameter int ADDR_W = 9
) (
    input  logic                        clk,
    input  logic [ADDR_W-1:0]           rd_addr,
    output logic [LANES-1:0][WIDTH-1:0] rd_data,
    input  logic [LANES-1:0]            wr_en,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [LANES-1:0][WIDTH-1:0] wr_data
);
    logic [LANES-1:0][WIDTH-1:0] mem_q [2**ADDR_W];
    logic [LANES-1:0][WIDTH-1:0] rd_data_q;

    assign rd_data = rd_data_q;

    always_ff @(posedge clk) begin
        rd_data_q <= mem_q[rd_addr];
        for (int i = 0; i < LANES; i++) begin
            if (wr_en[i]) begin
                mem_q[wr_addr][i] <= wr_data[i];
            end
        end
    end
endmodule

// File: rtl/vec_regram_core.sv
// Vector register bank + line RAM executing one masked command at a time.
// mult runs lane-serially, one lane per cycle.
module vec_regram_core
    import regram_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int LANES  = 16,
    parameter int ADDR_W = 9,
    parameter int NREG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    vec_regram_core_if.slave bus
);
    localparam int CNT_W = $clog2(LANES);
    localparam int SEL_W = $clog2(NREG);

    typedef logic [LANES-1:0][WIDTH-1:0] vec_t;

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  k_q, k_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [SEL_W-1:0]  src_q, src_d;
    logic [WIDTH-1:0]  imm_q, imm_d;
    vec_t              in_q, in_d;
    vec_t              out_q, out_d;
    vec_t              regs_q [NREG];
    vec_t              regs_d [NREG];
    logic              done_q, done_d;

    logic              accept;
    logic [LANES-1:0]  mask;
    logic [LANES-1:0]  wr_en;
    vec_t              wr_data;
    vec_t              rd_data;

    assign bus.cmd_ready  = (state_q == ST_IDLE) && !rst;
    assign accept         = bus.cmd_valid && bus.cmd_ready;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.done       = done_q;
    assign bus.ram_output = out_q;

    // The RAM read is launched with the live address at the accept edge,
    // so the line is ready during EXEC.
    vec_ram #(
        .WIDTH (WIDTH),
        .LANES (LANES),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk    (clk),
        .rd_addr(bus.ram_addr),
        .rd_data(rd_data),
        .wr_en  (wr_en & {LANES{!rst}}),
        .wr_addr(addr_q),
        .wr_data(wr_data)
    );

    always_comb begin
        mask = '0;
        for (int i = 0; i < LANES; i++) begin
            mask[i] = (CNT_W'(i) <= cnt_q);
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        sel_d   = sel_q;
        src_d   = src_q;
        imm_d   = imm_q;
        in_d    = in_q;
        out_d   = out_q;
        regs_d  = regs_q;
        done_d  = 1'b0;
        wr_en   = '0;
        wr_data = in_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d    = op_e'(bus.op);
                    addr_d  = bus.ram_addr;
                    cnt_d   = bus.ram_cnt;
                    sel_d   = bus.reg_sel;
                    src_d   = bus.reg_src;
                    imm_d   = bus.imm;
                    in_d    = bus.ram_input;
                    k_d     = '0;
                    state_d = (op_e'(bus.op) == OP_MULT) ? ST_MUL : ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                unique case (op_q)
                    OP_RAM_TO_REG: begin
                        for (int i = 0; i < LANES; i++) begin
                            if (mask[i]) regs_d[sel_q][i] = rd_data[i];
                        end
                    end
                    OP_REG_TO_RAM: begin
                        wr_en   = mask;
                        wr_data = regs_q[sel_q];
                    end
                    OP_ADDI: begin
                        for (int i = 0; i < LANES; i++) begin
                            if (mask[i]) regs_d[sel_q][i] = regs_q[sel_q][i] + imm_q;
                        end
                    end
                    OP_RAM_TO_OUT: begin
                        for (int i = 0; i < LANES; i++) begin
                            out_d[i] = mask[i] ? rd_data[i] : '0;
                        end
                    end
                    OP_OUT_TO_RAM: begin
                        wr_en = mask;
                    end
                    default: ;
                endcase
            end
            ST_MUL: begin
                // Operands come from the pre-edge bank, so sel==src squares.
                regs_d[sel_q][k_q] = regs_q[sel_q][k_q] * regs_q[src_q][k_q];
                k_d = k_q + CNT_W'(1);
                if (k_q == cnt_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    k_d     = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_RAM_TO_REG;
            addr_q  <= '0;
            cnt_q   <= '0;
            k_q     <= '0;
            sel_q   <= '0;
            src_q   <= '0;
            imm_q   <= '0;
            in_q    <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            sel_q   <= sel_d;
            src_q   <= src_d;
            imm_q   <= imm_d;
            in_q    <= in_d;
            out_q   <= out_d;
            done_q  <= done_d;
            regs_q  <= regs_d;
        end
    end
endmodule

// File: tb/tb_vec_regram_core.sv
// Bench for vec_regram_core: command table with an output scoreboard,
// plus hand sequences for mult abort, held cmd_valid and reset priority.
module tb_vec_regram_core;
    import regram_pkg::*;

    localparam int W  = 32;
    localparam int L  = 16;
    localparam int AW = 9;
    localparam int NR = 4;
    localparam int LW = $clog2(L);
    localparam int RW = $clog2(NR);

    typedef logic [L-1:0][W-1:0] vec_t;

    typedef struct {
        logic [2:0]    op;
        logic [AW-1:0] addr;
        logic [LW-1:0] cnt;
        logic [RW-1:0] sel;
        logic [RW-1:0] src;
        logic [W-1:0]  imm;
        vec_t          din;
        vec_t          want;
        int            lat;
    } vec_rec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vec_regram_core_if #(.WIDTH(W), .LANES(L), .ADDR_W(AW), .NREG(NR)) bus ();

    vec_regram_core #(.WIDTH(W), .LANES(L), .ADDR_W(AW), .NREG(NR)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t exp_q[$];
    vec_t last_out;
    vec_rec_t tbl[$];

    task automatic check(input string name, input logic [L*W-1:0] act, input logic [L*W-1:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    function automatic vec_t fill(input logic [W-1:0] v);
        vec_t r;
        for (int i = 0; i < L; i++) r[i] = v;
        return r;
    endfunction

    function automatic vec_t ramp();
        vec_t r;
        for (int i = 0; i < L; i++) r[i] = 32'h1000 + W'(i);
        return r;
    endfunction

    // lanes 0..cnt from lo, the rest from hi
    function automatic vec_t merge(input vec_t lo, input vec_t hi, input int cnt);
        vec_t r;
        for (int i = 0; i < L; i++) r[i] = (i <= cnt) ? lo[i] : hi[i];
        return r;
    endfunction

    function automatic vec_rec_t rec(input int op, input int addr, input int cnt,
                                     input int sel, input int src, input logic [W-1:0] imm,
                                     input vec_t din, input vec_t want, input int lat);
        vec_rec_t r;
        r.op   = 3'(op);
        r.addr = AW'(addr);
        r.cnt  = LW'(cnt);
        r.sel  = RW'(sel);
        r.src  = RW'(src);
        r.imm  = imm;
        r.din  = din;
        r.want = want;
        r.lat  = lat;
        return r;
    endfunction

    task automatic drive(input vec_rec_t r);
        bus.op        = r.op;
        bus.ram_addr  = r.addr;
        bus.ram_cnt   = r.cnt;
        bus.reg_sel   = r.sel;
        bus.reg_src   = r.src;
        bus.imm       = r.imm;
        bus.ram_input = r.din;
    endtask

    task automatic run_cmd(input vec_rec_t r, input string tag);
        int n;
        int nb;
        bit got;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, bus.cmd_ready, 1);
        drive(r);
        bus.cmd_valid = 1'b1;
        if (r.op == 3'd4) exp_q.push_back(r.want);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        n   = 0;
        nb  = 0;
        got = 1'b0;
        while (!got && n < r.lat + 8) begin
            @(negedge clk);
            n++;
            if (bus.busy === 1'b1) nb++;
            if (bus.done === 1'b1) got = 1'b1;
        end
        check({tag, "_latency"}, n, r.lat);
        check({tag, "_busy_cycles"}, nb, r.lat - 1);
        if (r.op == 3'd4) begin
            last_out = exp_q.pop_front();
            check({tag, "_ram_output"}, bus.ram_output, last_out);
        end else begin
            check({tag, "_out_hold"}, bus.ram_output, last_out);
        end
        @(negedge clk);
        check({tag, "_done_pulse"}, bus.done, 0);
    endtask

    task automatic expect_line(input int addr, input vec_t want, input string tag);
        run_cmd(rec(4, addr, 15, 0, 0, 0, '0, want, 2), tag);
    endtask

    initial begin
        vec_t z;
        vec_t mexp;
        bit saw_done;
        z = '0;
        mexp = ramp();
        mexp[0] = mexp[0] * 19;
        mexp[1] = mexp[1] * 19;
        mexp[2] = mexp[2] * 9;

        // op, addr, cnt, sel, src, imm, din, want, latency
        tbl.push_back(rec(5, 10, 15, 0, 0, 0, ramp(), z, 2));
        tbl.push_back(rec(4, 10, 15, 0, 0, 0, z, ramp(), 2));
        tbl.push_back(rec(4, 10, 2, 0, 0, 0, z, merge(ramp(), z, 2), 2));
        tbl.push_back(rec(0, 10, 15, 2, 0, 0, z, z, 2));
        tbl.push_back(rec(1, 20, 15, 2, 0, 0, z, z, 2));
        tbl.push_back(rec(4, 20, 15, 0, 0, 0, z, ramp(), 2));
        tbl.push_back(rec(5, 5, 15, 0, 0, 0, fill(32'hFFFFFFFF), z, 2));
        tbl.push_back(rec(5, 5, 3, 0, 0, 0, z, z, 2));
        tbl.push_back(rec(4, 5, 15, 0, 0, 0, z, merge(z, fill(32'hFFFFFFFF), 3), 2));
        tbl.push_back(rec(5, 6, 15, 0, 0, 0, fill(32'hFFFFFFFF), z, 2));
        tbl.push_back(rec(0, 6, 15, 1, 0, 0, z, z, 2));
        tbl.push_back(rec(2, 0, 15, 1, 0, 2, z, z, 2));
        tbl.push_back(rec(1, 30, 15, 1, 0, 0, z, z, 2));
        tbl.push_back(rec(4, 30, 15, 0, 0, 0, z, fill(32'h1), 2));
        tbl.push_back(rec(2, 0, 15, 1, 0, 2, z, z, 2));
        tbl.push_back(rec(3, 0, 15, 1, 1, 0, z, z, 17));
        tbl.push_back(rec(1, 31, 15, 1, 0, 0, z, z, 2));
        tbl.push_back(rec(4, 31, 15, 0, 0, 0, z, fill(32'h9), 2));
        tbl.push_back(rec(2, 0, 1, 1, 0, 10, z, z, 2));
        tbl.push_back(rec(0, 10, 15, 3, 0, 0, z, z, 2));
        tbl.push_back(rec(3, 0, 2, 3, 1, 0, z, z, 4));
        tbl.push_back(rec(1, 32, 15, 3, 0, 0, z, z, 2));
        tbl.push_back(rec(4, 32, 15, 0, 0, 0, z, mexp, 2));
        tbl.push_back(rec(6, 0, 15, 0, 0, 0, z, z, 2));
        tbl.push_back(rec(7, 0, 15, 0, 0, 0, z, z, 2));

        bus.cmd_valid = 1'b0;
        drive(rec(0, 0, 0, 0, 0, 0, z, z, 2));
        last_out = '0;

        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_cmd_ready", bus.cmd_ready, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_ram_output", bus.ram_output, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", bus.cmd_ready, 1);

        foreach (tbl[i]) run_cmd(tbl[i], $sformatf("v%0d", i));

        // mult cnt 7 on r2 (ramp), reset after four lane writes
        drive(rec(3, 0, 7, 2, 2, 0, z, z, 9));
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        saw_done = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1 saw_done |= (bus.done === 1'b1);
        end
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy_before", bus.busy, 1);
        check("abort_ready_in_rst", bus.cmd_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_busy_after", bus.busy, 0);
        check("abort_out_cleared", bus.ram_output, 0);
        repeat (10) begin
            @(negedge clk);
            saw_done |= (bus.done === 1'b1);
        end
        check("abort_no_done", saw_done, 0);
        last_out = '0;
        for (int r = 0; r < NR; r++) begin
            run_cmd(rec(1, 100 + r, 15, r, 0, 0, z, z, 2), $sformatf("abort_st_r%0d", r));
            expect_line(100 + r, z, $sformatf("abort_reg%0d_zero", r));
        end
        expect_line(10, ramp(), "abort_ram10");
        expect_line(31, fill(32'h9), "abort_ram31");
        expect_line(32, mexp, "abort_ram32");

        // cmd_valid held high with a different command while busy
        run_cmd(rec(5, 7, 15, 0, 0, 0, fill(32'h77), z, 2), "hold_pre");
        drive(rec(2, 0, 15, 0, 0, 5, z, z, 2));
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1 drive(rec(5, 7, 15, 0, 0, 100, fill(32'hAA), z, 2));
        @(negedge clk);
        check("hold_busy", bus.busy, 1);
        check("hold_not_ready", bus.cmd_ready, 0);
        @(negedge clk);
        check("hold_done", bus.done, 1);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("hold_idle", bus.busy, 0);
        run_cmd(rec(1, 50, 15, 0, 0, 0, z, z, 2), "hold_st");
        expect_line(50, fill(32'h5), "hold_r0");
        expect_line(7, fill(32'h77), "hold_ram7");

        // reset and cmd_valid together: command dropped
        run_cmd(rec(5, 40, 15, 0, 0, 0, fill(32'h40), z, 2), "rw_pre");
        drive(rec(5, 40, 15, 0, 0, 0, fill(32'hBB), z, 2));
        rst = 1'b1;
        bus.cmd_valid = 1'b1;
        #1 check("rw_ready", bus.cmd_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("rw_busy", bus.busy, 0);
        last_out = '0;
        expect_line(40, fill(32'h40), "rw_ram40");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
